// File: rtl/fpa_pkg.sv
// Shared types and format helpers for the pipelined floating-point adder.
package fpa_pkg;

    typedef enum logic [1:0] {
        SP_NONE,
        SP_NAN,
        SP_INF
    } spec_e;

    function automatic int fpa_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic int fpa_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int fpa_exp_max(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

endpackage

// File: rtl/fpa_pipe_adder_if.sv
// Operand/result handshake bundle for fpa_pipe_adder.
interface fpa_pipe_adder_if
    import fpa_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
);
    localparam int W = fpa_w(EXP_W, MAN_W);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_ovf;
    logic         out_unf;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, out_unf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, out_unf
    );
endinterface

// File: rtl/fpa_lzc.sv
// Leading-zero counter; an all-zero input yields WIDTH.
module fpa_lzc #(
    parameter int WIDTH = 15,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CW-1:0]    count
);
    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) count = CW'(WIDTH - 1 - i);
        end
    end
endmodule

// File: rtl/fpa_pipe_adder.sv
// Four-cycle pipelined FP add/sub: capture, unpack/swap, align, add, normalise/round/pack.
// Build option: FPA_ROUND_RNE_EN selects round-to-nearest-even, otherwise truncation.
module fpa_pipe_adder
    import fpa_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input logic             clk,
    input logic             rst,
    fpa_pipe_adder_if.slave bus
);
    localparam int W       = fpa_w(EXP_W, MAN_W);
    localparam int EXP_MAX = fpa_exp_max(EXP_W);
    localparam int SW      = MAN_W + 5;
    localparam int LZ_W    = $clog2(SW + 1);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   mant;
        logic             is_zero;
        logic             is_inf;
        logic             is_nan;
    } unpk_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp_x;
        logic [EXP_W-1:0] exp_y;
        logic [MAN_W:0]   mant_x;
        logic [MAN_W:0]   mant_y;
        logic             eff_sub;
        spec_e            spec;
        logic             spec_sign;
    } s1_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W+3:0] mx;
        logic [MAN_W+3:0] my;
        logic             eff_sub;
        spec_e            spec;
        logic             spec_sign;
    } s2_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SW-1:0]    sum;
        spec_e            spec;
        logic             spec_sign;
    } s3_t;

    function automatic unpk_t unpack(input logic [W-1:0] v, input logic flip);
        unpk_t u;
        u.sign    = v[W-1] ^ flip;
        u.is_zero = (v[W-2:MAN_W] == '0);
        u.is_inf  = (v[W-2:MAN_W] == EXP_ONES) && (v[MAN_W-1:0] == '0);
        u.is_nan  = (v[W-2:MAN_W] == EXP_ONES) && (v[MAN_W-1:0] != '0);
        u.exp     = u.is_zero ? '0 : v[W-2:MAN_W];
        u.mant    = u.is_zero ? '0 : {1'b1, v[MAN_W-1:0]};
        return u;
    endfunction

    logic             v0, v1, v2, v3, out_valid_q;
    logic [W-1:0]     a0, b0;
    logic             sub0;
    s1_t              r1, n1;
    s2_t              r2, n2;
    s3_t              r3, n3;
    logic [W-1:0]     out_sum_q, sum_n;
    logic             out_ovf_q, out_unf_q, ovf_n, unf_n;
    logic             stall;

    assign stall         = out_valid_q & ~bus.out_ready;
    assign bus.in_ready  = ~stall;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_unf   = out_unf_q;

    // S1: unpack, apply subtract, order operands by magnitude, classify specials
    unpk_t          ua, ub;
    logic [W-2:0]   ka, kb;
    logic           swap;

    always_comb begin
        ua   = unpack(a0, 1'b0);
        ub   = unpack(b0, sub0);
        ka   = ua.is_zero ? '0 : a0[W-2:0];
        kb   = ub.is_zero ? '0 : b0[W-2:0];
        swap = kb > ka;
        n1           = '0;
        n1.sign      = swap ? ub.sign : ua.sign;
        n1.exp_x     = swap ? ub.exp  : ua.exp;
        n1.exp_y     = swap ? ua.exp  : ub.exp;
        n1.mant_x    = swap ? ub.mant : ua.mant;
        n1.mant_y    = swap ? ua.mant : ub.mant;
        n1.eff_sub   = ua.sign ^ ub.sign;
        n1.spec      = SP_NONE;
        n1.spec_sign = 1'b0;
        if (ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_inf && (ua.sign != ub.sign))) begin
            n1.spec = SP_NAN;
        end else if (ua.is_inf) begin
            n1.spec      = SP_INF;
            n1.spec_sign = ua.sign;
        end else if (ub.is_inf) begin
            n1.spec      = SP_INF;
            n1.spec_sign = ub.sign;
        end
    end

    // S2: align Y with guard/round/sticky
    logic [EXP_W-1:0] diff;
    logic [MAN_W+3:0] ext_y, sh_y;
    logic             sticky;

    always_comb begin
        diff   = r1.exp_x - r1.exp_y;
        ext_y  = {r1.mant_y, 3'b000};
        sh_y   = ext_y >> diff;
        sticky = 1'b0;
        for (int i = 0; i < MAN_W + 4; i++) begin
            if (i < int'(diff)) sticky = sticky | ext_y[i];
        end
        n2           = '0;
        n2.sign      = r1.sign;
        n2.exp       = r1.exp_x;
        n2.mx        = {r1.mant_x, 3'b000};
        n2.eff_sub   = r1.eff_sub;
        n2.spec      = r1.spec;
        n2.spec_sign = r1.spec_sign;
        if (int'(diff) >= MAN_W + 3) n2.my = {{(MAN_W+3){1'b0}}, |r1.mant_y};
        else                         n2.my = {sh_y[MAN_W+3:1], sh_y[0] | sticky};
    end

    // S3: magnitude add/subtract; X >= Y so the difference never goes negative
    always_comb begin
        n3           = '0;
        n3.sign      = r2.sign;
        n3.exp       = r2.exp;
        n3.sum       = r2.eff_sub ? ({1'b0, r2.mx} - {1'b0, r2.my})
                                  : ({1'b0, r2.mx} + {1'b0, r2.my});
        n3.spec      = r2.spec;
        n3.spec_sign = r2.spec_sign;
    end

    // S4: normalise, round, pack, resolve specials
    logic [LZ_W-1:0]  lz, lz_sh;
    logic [MAN_W+3:0] norm;
    logic [MAN_W-1:0] frac;
    int               exp_n;

    fpa_lzc #(.WIDTH(SW), .CW(LZ_W)) u_lzc (
        .value (r3.sum),
        .count (lz)
    );

`ifdef FPA_ROUND_RNE_EN
    logic             inc;
    logic [MAN_W+1:0] rnd;
`else
    logic [3:0]       unused_grs;
`endif

    always_comb begin
        lz_sh = lz - LZ_W'(1);
        if (r3.sum[SW-1]) begin
            norm  = {r3.sum[SW-1:2], r3.sum[1] | r3.sum[0]};
            exp_n = int'(r3.exp) + 1;
        end else begin
            norm  = r3.sum[SW-2:0] << lz_sh;
            exp_n = int'(r3.exp) - int'(lz_sh);
        end
`ifdef FPA_ROUND_RNE_EN
        inc = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd = {1'b0, norm[MAN_W+3:3]} + (MAN_W+2)'(inc);
        if (rnd[MAN_W+1]) begin
            frac  = rnd[MAN_W:1];
            exp_n = exp_n + 1;
        end else begin
            frac  = rnd[MAN_W-1:0];
        end
`else
        unused_grs = {norm[MAN_W+3], norm[2:0]};
        frac       = norm[MAN_W+2:3];
`endif
        sum_n = '0;
        ovf_n = 1'b0;
        unf_n = 1'b0;
        if (r3.spec == SP_NAN) begin
            sum_n = QNAN;
        end else if (r3.spec == SP_INF) begin
            sum_n = {r3.spec_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (r3.sum == '0) begin
            sum_n = '0;
        end else if (exp_n >= EXP_MAX) begin
            sum_n = {r3.sign, EXP_ONES, {MAN_W{1'b0}}};
            ovf_n = 1'b1;
        end else if (exp_n <= 0) begin
            sum_n = {r3.sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
            unf_n = 1'b1;
        end else begin
            sum_n = {r3.sign, exp_n[EXP_W-1:0], frac};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0          <= 1'b0;
            a0          <= '0;
            b0          <= '0;
            sub0        <= 1'b0;
            v1          <= 1'b0;
            r1          <= '0;
            v2          <= 1'b0;
            r2          <= '0;
            v3          <= 1'b0;
            r3          <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_unf_q   <= 1'b0;
        end else if (!stall) begin
            v0          <= bus.in_valid;
            a0          <= bus.in_a;
            b0          <= bus.in_b;
            sub0        <= bus.in_sub;
            v1          <= v0;
            r1          <= n1;
            v2          <= v1;
            r2          <= n2;
            v3          <= v2;
            r3          <= n3;
            out_valid_q <= v3;
            out_sum_q   <= v3 ? sum_n : '0;
            out_ovf_q   <= v3 & ovf_n;
            out_unf_q   <= v3 & unf_n;
        end
    end
endmodule

// File: tb/tb_fpa_pipe_adder.sv
// Scoreboard bench for fpa_pipe_adder (half precision); honours FPA_ROUND_RNE_EN.
module tb_fpa_pipe_adder;
    localparam bit RNE =
`ifdef FPA_ROUND_RNE_EN
        1'b1;
`else
        1'b0;
`endif

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fpa_pipe_adder_if #(.EXP_W(5), .MAN_W(10)) bus ();

    fpa_pipe_adder #(.EXP_W(5), .MAN_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [15:0] sum;
        logic        ovf;
        logic        unf;
        bit          chk_lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t head;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   head_seen = 1'b0;
    bit   drop_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Call at a negedge; returns at the negedge following acceptance.
    task automatic send(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic [15:0] r, input logic o, input logic u,
                        input bit lat, input bit push);
        int tries = 0;
        bit done = 1'b0;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
        while (!done) begin
            #2;
            if (bus.in_ready) begin
                if (push) begin
                    e.name = name; e.sum = r; e.ovf = o; e.unf = u;
                    e.chk_lat = lat; e.acc = cyc + 1;
                    sb.push_back(e);
                end
                done = 1'b1;
            end
            @(negedge clk);
            if (!done) begin
                tries++;
                if (tries > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL %s_accept: in_ready stayed 0, expected 1 within 50 cycles", name);
                    done = 1'b1;
                end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    // Monitor: pops and compares whenever a result transfers
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && !drop_mode && bus.out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out: out_valid=1 sum=%h, expected no result", bus.out_sum);
                end else begin
                    head = sb[0];
                    if (!head_seen) begin
                        head_seen = 1'b1;
                        if (head.chk_lat) chk({head.name, "_latency"}, cyc - head.acc, 4);
                    end
                    if (bus.out_ready) begin
                        sb.delete(0);
                        head_seen = 1'b0;
                        chk(head.name, {bus.out_ovf, bus.out_unf, bus.out_sum},
                            {head.ovf, head.unf, head.sum});
                    end else begin
                        chk({head.name, "_hold"}, bus.out_sum, head.sum);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int seen;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_fields", {bus.out_ovf, bus.out_unf, bus.out_sum}, 0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("in_ready_after_rst", bus.in_ready, 1);
        @(negedge clk);

        send("one_plus_two", 16'h3C00, 16'h4000, 1'b0, 16'h4200, 1'b0, 1'b0, 1'b1, 1'b1);
        send("cancel",       16'h3C00, 16'h3C00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        send("overflow",     16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1'b1, 1'b0, 1'b1, 1'b1);
        send("underflow",    16'h0401, 16'h0400, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1);
        send("denorm_flush", 16'h03FF, 16'h3C00, 1'b0, 16'h3C00, 1'b0, 1'b0, 1'b1, 1'b1);
        send("round_075ulp", 16'h3C00, 16'h1200, 1'b0, RNE ? 16'h3C01 : 16'h3C00, 1'b0, 1'b0, 1'b1, 1'b1);
        send("round_15ulp",  16'h3C00, 16'h1600, 1'b0, RNE ? 16'h3C02 : 16'h3C01, 1'b0, 1'b0, 1'b1, 1'b1);
        send("round_carry",  16'h3BFF, 16'h0C00, 1'b0, RNE ? 16'h3C00 : 16'h3BFF, 1'b0, 1'b0, 1'b1, 1'b1);
        send("inf_minus_inf",16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 1'b0, 1'b0, 1'b1, 1'b1);
        send("nan_in",       16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 1'b0, 1'b0, 1'b1, 1'b1);
        send("neg_inf",      16'hFC00, 16'h3C00, 1'b0, 16'hFC00, 1'b0, 1'b0, 1'b1, 1'b1);
        send("two_minus_one",16'h4000, 16'h3C00, 1'b1, 16'h3C00, 1'b0, 1'b0, 1'b1, 1'b1);
        send("one_minus_two",16'h3C00, 16'h4000, 1'b1, 16'hBC00, 1'b0, 1'b0, 1'b1, 1'b1);
        send("zero_plus_b",  16'h0000, 16'hC500, 1'b0, 16'hC500, 1'b0, 1'b0, 1'b1, 1'b1);
        send("zero_minus_b", 16'h0000, 16'h4500, 1'b1, 16'hC500, 1'b0, 1'b0, 1'b1, 1'b1);
        send("carry_out",    16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0, 1'b0, 1'b1, 1'b1);
        send("far_shift",    16'h7800, 16'h0400, 1'b0, 16'h7800, 1'b0, 1'b0, 1'b1, 1'b1);
        drain();

        fork
            begin
                send("bp0", 16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0, 1'b0, 1'b0, 1'b1);
                send("bp1", 16'h4000, 16'h4000, 1'b0, 16'h4400, 1'b0, 1'b0, 1'b0, 1'b1);
                send("bp2", 16'h4200, 16'h3C00, 1'b0, 16'h4400, 1'b0, 1'b0, 1'b0, 1'b1);
                send("bp3", 16'h4400, 16'h3C00, 1'b1, 16'h4200, 1'b0, 1'b0, 1'b0, 1'b1);
                send("bp4", 16'h3C00, 16'h0000, 1'b0, 16'h3C00, 1'b0, 1'b0, 1'b0, 1'b1);
                send("bp5", 16'hC000, 16'hC000, 1'b0, 16'hC400, 1'b0, 1'b0, 1'b0, 1'b1);
            end
            begin
                repeat (5) @(negedge clk);
                bus.out_ready = 1'b0;
                #2;
                chk("bp_in_ready_low", bus.in_ready, 0);
                repeat (3) @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Three operations in flight, then reset: none may ever appear
        bus.out_ready = 1'b0;
        drop_mode     = 1'b1;
        send("drop0", 16'h3C00, 16'h4000, 1'b0, 16'h4200, 1'b0, 1'b0, 1'b0, 1'b0);
        send("drop1", 16'h4000, 16'h4000, 1'b0, 16'h4400, 1'b0, 1'b0, 1'b0, 1'b0);
        send("drop2", 16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("inflight_valid_before_rst", bus.out_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_kills_out_valid", bus.out_valid, 0);
        chk("rst_clears_out", {bus.out_ovf, bus.out_unf, bus.out_sum}, 0);
        @(negedge clk);
        @(negedge clk);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        drop_mode     = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            #2;
            if (bus.out_valid) seen++;
        end
        chk("flushed_never_emerge", seen, 0);
        chk("in_ready_after_flush", bus.in_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
